learn_note_feeder: RTL and testbench
====================================

Name: learn_note_feeder

Overview:
- Song sequencer that drives the learn-mode note display.
- Fetches song entries from a synchronous song ROM and presents one note mask, octave shift and valid flag per scroll tick.
- Advances only on ticks where the display scrolls, i.e. the player has matched the bottom-row notes. The feeder therefore pauses together with the display.
- Sits between the song ROM and the learn-mode VGA layer, in the vga_clk domain.

Parameters:
TICK_PERIOD, 100000, vga_clk cycles per scroll tick; must equal the display scroll period, minimum 4
ADDR_W, 8, song ROM address width
GAP_TICKS, 1, accepted ticks of silence inserted after every note

Ports:
vga_clk  in  1  pixel clock
rst_n  in  1  reset
start  in  1  one-cycle pulse; begin song at address 0
stop  in  1  one-cycle pulse; abort song
rom_addr  out  ADDR_W  song ROM address
rom_data  in  16  ROM word, valid 1 cycle after rom_addr; [15:8] note mask (bit0=C .. bit6=B, bit7 spare), [7:6] shift, [5:0] length in ticks
vga_bottom  in  10  bottom-row note bits from the display; [8:2] = B..C, [1:0] = shift
key  in  8  player keys; key[7]=C .. key[1]=B
note  out  8  note mask to display
shift  out  2  octave: 00 middle, 01 low, 10 high
output_ready  out  1  note valid qualifier
busy  out  1  song in progress
done  out  1  one-cycle pulse at song end
stall_cnt  out  8  saturating count of ticks blocked by a player miss

Behaviour:
- Reset (rst_n asynchronous, active-low; clock vga_clk):
  - All outputs 0. State IDLE. Tick counter 0.
- Tick counter:
  - Counts 0..TICK_PERIOD-1. tick=1 on the cycle after the count reaches TICK_PERIOD-1.
  - This matches the display timing, so both stay aligned from a common reset.
- Acceptance:
  - accept = tick && (vga_bottom[8:2] == {key[1],key[2],key[3],key[4],key[5],key[6],key[7]}).
  - This is the same condition the display uses to shift.
- FSM states: IDLE, FETCH, LOAD, PLAY, GAP, DONE.
- IDLE:
  - note=0, output_ready=0, busy=0.
  - start -> FETCH with rom_addr=0.
- FETCH:
  - Holds rom_addr for one cycle, then -> LOAD.
- LOAD:
  - Registers rom_data. If length==0 -> DONE.
  - Otherwise: note<=mask, shift<=[7:6], output_ready<=1, remaining<=length, then -> PLAY.
- PLAY:
  - On accept, remaining decrements. If remaining was 1: note<=0, output_ready<=0, gap counter<=GAP_TICKS, then -> GAP.
  - GAP_TICKS=0 skips GAP and goes to the fetch step.
  - Mask 0 with nonzero length is a rest: output_ready=1, note=0.
- GAP:
  - note=0, output_ready=0.
  - Each accept decrements the gap counter. At 0: if rom_addr is the last address (2^ADDR_W-1) -> DONE; otherwise rom_addr+1 -> FETCH.
  - FETCH and LOAD take 2 cycles, well inside one tick period, so no tick is lost.
- DONE:
  - done=1 for exactly one cycle, then -> IDLE.
  - shift holds its last value; rom_addr returns to 0.
- Stall:
  - Tick without accept while in PLAY or GAP: stall_cnt+1, saturating at 255.
  - Cleared on each accepted start.
- busy = 1 in FETCH, LOAD, PLAY and GAP.
- start while busy is ignored.
- stop in any state:
  - Next cycle -> IDLE; note, output_ready and busy go to 0; rom_addr goes to 0.
  - No done pulse.
  - stop has priority over start in the same cycle.
- tick coinciding with FETCH or LOAD is not counted as stall and is not consumed.
- Asynchronous reset mid-song returns immediately to reset values.

Test Plan:
- Reset: assert rst_n=0 mid-PLAY -> note=0, output_ready=0, busy=0, done=0, rom_addr=0, stall_cnt=0 immediately.
- Basic song, TICK_PERIOD=4, keys matching (all 0), ROM[0]=16'h0103, ROM[1]=0, start pulse:
  - note=8'h01, output_ready=1 for exactly 3 ticks;
  - then 1 tick note=0, output_ready=0;
  - then rom_addr=1, done pulse, busy=0.
- Stall: during PLAY force vga_bottom[2]=1, key[7]=0 for 5 ticks -> remaining frozen, note held, stall_cnt=5. Set key[7]=1 -> countdown resumes on the next tick.
- Octave/rest: ROM[0]=16'h0082 -> shift=10, note=0, output_ready=1 for 2 ticks.
- Stop/start priority:
  - stop in PLAY -> next cycle IDLE, no done pulse.
  - start pulse while busy -> no restart; rom_addr unchanged.
  - start and stop together in IDLE -> stays IDLE.
- Address wrap: ADDR_W=2, ROM all 16'h0201 -> 4 notes of mask 8'h02 play, then done pulse after address 3; no fetch of address 0.

Source files
------------

// File: rtl/learn_note_feeder.sv
// Learn-mode song sequencer: walks the song ROM and presents one note per
// scroll tick, pausing whenever the display pauses for a player miss.
module learn_note_feeder #(
    parameter int TICK_PERIOD = 100000,
    parameter int ADDR_W      = 8,
    parameter int GAP_TICKS   = 1
) (
    input  logic              vga_clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    input  logic [9:0]        vga_bottom,
    input  logic [7:0]        key,
    output logic [7:0]        note,
    output logic [1:0]        shift,
    output logic              output_ready,
    output logic              busy,
    output logic              done,
    output logic [7:0]        stall_cnt
);

    localparam int CNT_W = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
    localparam int GAP_W = $clog2(GAP_TICKS + 2);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TICK_PERIOD - 1);
    localparam logic [GAP_W-1:0]  GAP_INIT  = GAP_W'(GAP_TICKS);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        PLAY  = 3'd3,
        GAP   = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  tickCnt_q, tickCnt_d;
    logic              tick_q, tick_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        note_q, note_d;
    logic [1:0]        shift_q, shift_d;
    logic              ready_q, ready_d;
    logic [5:0]        remain_q, remain_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [7:0]        stall_q, stall_d;

    logic [6:0] keyNotes;
    logic       notesMatch;
    logic       accept;
    logic       stallHit;
    logic       stepNext;
    logic       unused_ok;

    // Free-running tick generator; kept identical to the display's so both
    // scroll on the same cycle after a shared reset.
    always_comb begin
        tickCnt_d = (tickCnt_q == CNT_LAST) ? '0 : tickCnt_q + CNT_W'(1);
        tick_d    = (tickCnt_q == CNT_LAST);
    end

    assign keyNotes   = {key[1], key[2], key[3], key[4], key[5], key[6], key[7]};
    assign notesMatch = (vga_bottom[8:2] == keyNotes);
    assign accept     = tick_q && notesMatch;
    assign stallHit   = tick_q && !notesMatch && (state_q == PLAY || state_q == GAP);
    assign unused_ok  = &{1'b0, vga_bottom[9], vga_bottom[1:0], key[0]};

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        note_d   = note_q;
        shift_d  = shift_q;
        ready_d  = ready_q;
        remain_d = remain_q;
        gap_d    = gap_q;
        stall_d  = stall_q;
        stepNext = 1'b0;

        if (stallHit && stall_q != 8'hFF) begin
            stall_d = stall_q + 8'd1;
        end

        if (stop) begin
            state_d = IDLE;
            addr_d  = '0;
            note_d  = '0;
            ready_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    note_d  = '0;
                    ready_d = 1'b0;
                    if (start) begin
                        state_d = FETCH;
                        addr_d  = '0;
                        stall_d = '0;
                    end
                end
                FETCH: state_d = LOAD;
                LOAD: begin
                    if (rom_data[5:0] == 6'd0) begin
                        state_d = DONE;
                    end else begin
                        note_d   = rom_data[15:8];
                        shift_d  = rom_data[7:6];
                        ready_d  = 1'b1;
                        remain_d = rom_data[5:0];
                        state_d  = PLAY;
                    end
                end
                PLAY: begin
                    if (accept) begin
                        remain_d = remain_q - 6'd1;
                        if (remain_q <= 6'd1) begin
                            note_d  = '0;
                            ready_d = 1'b0;
                            if (GAP_TICKS == 0) begin
                                stepNext = 1'b1;
                            end else begin
                                gap_d   = GAP_INIT;
                                state_d = GAP;
                            end
                        end
                    end
                end
                GAP: begin
                    note_d  = '0;
                    ready_d = 1'b0;
                    if (accept) begin
                        if (gap_q <= GAP_W'(1)) begin
                            gap_d    = '0;
                            stepNext = 1'b1;
                        end else begin
                            gap_d = gap_q - GAP_W'(1);
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    addr_d  = '0;
                end
                default: state_d = IDLE;
            endcase

            // The last ROM address ends the song instead of wrapping to 0.
            if (stepNext) begin
                if (addr_q == ADDR_LAST) begin
                    state_d = DONE;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = FETCH;
                end
            end
        end
    end

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tickCnt_q <= '0;
            tick_q    <= 1'b0;
            addr_q    <= '0;
            note_q    <= '0;
            shift_q   <= '0;
            ready_q   <= 1'b0;
            remain_q  <= '0;
            gap_q     <= '0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            tickCnt_q <= tickCnt_d;
            tick_q    <= tick_d;
            addr_q    <= addr_d;
            note_q    <= note_d;
            shift_q   <= shift_d;
            ready_q   <= ready_d;
            remain_q  <= remain_d;
            gap_q     <= gap_d;
            stall_q   <= stall_d;
        end
    end

    assign rom_addr     = addr_q;
    assign note         = note_q;
    assign shift        = shift_q;
    assign output_ready = ready_q;
    assign stall_cnt    = stall_q;
    assign done         = (state_q == DONE);
    assign busy         = (state_q == FETCH) || (state_q == LOAD) ||
                          (state_q == PLAY)  || (state_q == GAP);

endmodule

// File: tb/tb_learn_note_feeder.sv
// Directed bench for learn_note_feeder: one 8-bit-address feeder plus a
// 2-bit-address copy for the end-of-ROM case, both with a 4-cycle tick.
module tb_learn_note_feeder;

    localparam int PERIOD = 4;

    logic        vgaClk = 1'b0;
    logic        rstN   = 1'b0;
    logic        startA = 1'b0;
    logic        startB = 1'b0;
    logic        stopA  = 1'b0;
    logic [9:0]  vgaBottom = '0;
    logic [7:0]  key       = '0;

    logic [7:0]  romAddrA;
    logic [15:0] romDataA;
    logic [7:0]  noteA, stallA;
    logic [1:0]  shiftA;
    logic        readyA, busyA, doneA;

    logic [1:0]  romAddrB;
    logic [15:0] romDataB;
    logic [7:0]  noteB, stallB;
    logic [1:0]  shiftB;
    logic        readyB, busyB, doneB;

    logic [15:0] romA [256];
    logic [15:0] romB [4];

    int cyc;
    int checks = 0;
    int errors = 0;

    always #5 vgaClk = ~vgaClk;

    // Cycles since reset release; tick cycles are the nonzero multiples of PERIOD.
    always @(posedge vgaClk or negedge rstN) begin
        if (!rstN) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    always @(posedge vgaClk) begin
        romDataA <= romA[romAddrA];
        romDataB <= romB[romAddrB];
    end

    learn_note_feeder #(.TICK_PERIOD(PERIOD), .ADDR_W(8), .GAP_TICKS(1)) dut (
        .vga_clk(vgaClk), .rst_n(rstN), .start(startA), .stop(stopA),
        .rom_addr(romAddrA), .rom_data(romDataA), .vga_bottom(vgaBottom), .key(key),
        .note(noteA), .shift(shiftA), .output_ready(readyA), .busy(busyA),
        .done(doneA), .stall_cnt(stallA)
    );

    learn_note_feeder #(.TICK_PERIOD(PERIOD), .ADDR_W(2), .GAP_TICKS(1)) dutWrap (
        .vga_clk(vgaClk), .rst_n(rstN), .start(startB), .stop(stopA),
        .rom_addr(romAddrB), .rom_data(romDataB), .vga_bottom(vgaBottom), .key(key),
        .note(noteB), .shift(shiftB), .output_ready(readyB), .busy(busyB),
        .done(doneB), .stall_cnt(stallB)
    );

    task automatic checkOutput(input string tag, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    // Pulses start/stop on feeder A for one cycle; called and returns at a negedge.
    task automatic applyStimulus(input logic s, input logic p);
        startA = s;
        stopA  = p;
        @(negedge vgaClk);
        startA = 1'b0;
        stopA  = 1'b0;
    endtask

    task automatic waitTick();
        for (int i = 0; i < 2 * PERIOD; i++) begin
            @(negedge vgaClk);
            if (cyc != 0 && (cyc % PERIOD) == 0) return;
        end
        checkOutput("waitTick_timeout", 16'd0, 16'd1);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge vgaClk);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int doneSeen;
        for (int i = 0; i < 256; i++) romA[i] = 16'h0000;
        for (int i = 0; i < 4; i++)   romB[i] = 16'h0201;

        waitCycles(2);
        rstN = 1'b1;
        waitCycles(1);
        checkOutput("reset_busy", {15'd0, busyA}, 16'd0);
        checkOutput("reset_note", {8'd0, noteA}, 16'd0);

        // Basic song: 3-tick note, 1 gap tick, then end marker at address 1.
        romA[0] = 16'h0103;
        romA[1] = 16'h0000;
        waitTick();
        applyStimulus(1'b1, 1'b0);
        checkOutput("basic_fetch_busy", {15'd0, busyA}, 16'd1);
        waitCycles(2);
        checkOutput("basic_play_note", {8'd0, noteA}, 16'h0001);
        for (int i = 0; i < 3; i++) begin
            waitTick();
            checkOutput("basic_tick_note", {8'd0, noteA}, 16'h0001);
            checkOutput("basic_tick_ready", {15'd0, readyA}, 16'd1);
        end
        waitTick();
        checkOutput("basic_gap_note", {8'd0, noteA}, 16'h0000);
        checkOutput("basic_gap_ready", {15'd0, readyA}, 16'd0);
        waitCycles(1);
        checkOutput("basic_fetch1_addr", {8'd0, romAddrA}, 16'd1);
        waitCycles(2);
        checkOutput("basic_done", {15'd0, doneA}, 16'd1);
        checkOutput("basic_done_busy", {15'd0, busyA}, 16'd0);
        checkOutput("basic_done_addr", {8'd0, romAddrA}, 16'd1);
        waitCycles(1);
        checkOutput("basic_done_once", {15'd0, doneA}, 16'd0);
        checkOutput("basic_idle_addr", {8'd0, romAddrA}, 16'd0);

        // Stall: C shown on the bottom row but not pressed for 5 ticks.
        romA[0] = 16'h0104;
        waitTick();
        applyStimulus(1'b1, 1'b0);
        waitTick();
        checkOutput("stall_first_note", {8'd0, noteA}, 16'h0001);
        waitCycles(1);
        vgaBottom = 10'b00_0000_0100;
        for (int i = 0; i < 5; i++) begin
            waitTick();
            checkOutput("stall_held_note", {8'd0, noteA}, 16'h0001);
        end
        waitCycles(1);
        checkOutput("stall_count", {8'd0, stallA}, 16'd5);
        key = 8'h80;
        for (int i = 0; i < 3; i++) begin
            waitTick();
            checkOutput("stall_resume_note", {8'd0, noteA}, 16'h0001);
        end
        waitTick();
        checkOutput("stall_gap_ready", {15'd0, readyA}, 16'd0);
        checkOutput("stall_gap_count", {8'd0, stallA}, 16'd5);
        waitTick();
        checkOutput("stall_end_busy", {15'd0, busyA}, 16'd0);
        vgaBottom = '0;
        key       = '0;

        // Octave shift and rest.
        romA[0] = 16'h0082;
        waitTick();
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            waitTick();
            checkOutput("rest_shift", {14'd0, shiftA}, 16'd2);
            checkOutput("rest_note", {8'd0, noteA}, 16'h0000);
            checkOutput("rest_ready", {15'd0, readyA}, 16'd1);
            checkOutput("rest_stall_cleared", {8'd0, stallA}, 16'd0);
        end
        waitTick();
        checkOutput("rest_gap_ready", {15'd0, readyA}, 16'd0);
        waitTick();
        checkOutput("rest_end_busy", {15'd0, busyA}, 16'd0);
        checkOutput("rest_shift_held", {14'd0, shiftA}, 16'd2);

        // Start while busy must not restart the song.
        romA[0] = 16'h0103;
        waitTick();
        applyStimulus(1'b1, 1'b0);
        waitTick();
        applyStimulus(1'b1, 1'b0);
        checkOutput("restart_addr", {8'd0, romAddrA}, 16'd0);
        checkOutput("restart_ready", {15'd0, readyA}, 16'd1);
        waitTick();
        waitTick();
        checkOutput("restart_last_note", {8'd0, noteA}, 16'h0001);
        waitTick();
        checkOutput("restart_gap_note", {8'd0, noteA}, 16'h0000);
        waitTick();
        checkOutput("restart_end_busy", {15'd0, busyA}, 16'd0);

        // Stop mid-note: straight to idle, no done pulse.
        waitTick();
        applyStimulus(1'b1, 1'b0);
        waitTick();
        waitCycles(1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("stop_busy", {15'd0, busyA}, 16'd0);
        checkOutput("stop_note", {8'd0, noteA}, 16'h0000);
        checkOutput("stop_ready", {15'd0, readyA}, 16'd0);
        checkOutput("stop_addr", {8'd0, romAddrA}, 16'd0);
        doneSeen = 0;
        for (int i = 0; i < 16; i++) begin
            if (doneA) doneSeen++;
            @(negedge vgaClk);
        end
        checkOutput("stop_no_done", doneSeen[15:0], 16'd0);

        // Start and stop together in idle.
        applyStimulus(1'b1, 1'b1);
        checkOutput("startstop_busy0", {15'd0, busyA}, 16'd0);
        waitCycles(2);
        checkOutput("startstop_busy2", {15'd0, busyA}, 16'd0);

        // Mid-song asynchronous reset with a nonzero stall count.
        waitTick();
        applyStimulus(1'b1, 1'b0);
        vgaBottom = 10'b00_0000_0100;
        waitTick();
        waitTick();
        waitCycles(1);
        checkOutput("prereset_stall", {8'd0, stallA}, 16'd2);
        checkOutput("prereset_note", {8'd0, noteA}, 16'h0001);
        #2 rstN = 1'b0;
        #1;
        checkOutput("areset_note", {8'd0, noteA}, 16'h0000);
        checkOutput("areset_ready", {15'd0, readyA}, 16'd0);
        checkOutput("areset_busy", {15'd0, busyA}, 16'd0);
        checkOutput("areset_done", {15'd0, doneA}, 16'd0);
        checkOutput("areset_addr", {8'd0, romAddrA}, 16'd0);
        checkOutput("areset_stall", {8'd0, stallA}, 16'd0);
        vgaBottom = '0;
        waitCycles(1);
        rstN = 1'b1;

        // End of a 4-entry ROM: four notes, then done without wrapping.
        waitTick();
        startB = 1'b1;
        @(negedge vgaClk);
        startB = 1'b0;
        for (int k = 0; k < 4; k++) begin
            waitTick();
            checkOutput("wrap_note", {8'd0, noteB}, 16'h0002);
            checkOutput("wrap_ready", {15'd0, readyB}, 16'd1);
            checkOutput("wrap_addr", {14'd0, romAddrB}, k[15:0]);
            waitTick();
            checkOutput("wrap_gap_note", {8'd0, noteB}, 16'h0000);
        end
        waitCycles(1);
        checkOutput("wrap_done", {15'd0, doneB}, 16'd1);
        checkOutput("wrap_done_addr", {14'd0, romAddrB}, 16'd3);
        waitCycles(1);
        checkOutput("wrap_done_once", {15'd0, doneB}, 16'd0);
        checkOutput("wrap_idle_busy", {15'd0, busyB}, 16'd0);
        waitTick();
        checkOutput("wrap_no_refetch", {15'd0, busyB}, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
